// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the ISDU/register file and the iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       drIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [2:0]       drOut;
  logic             ldReg;
  logic             divZero;
  logic             err;

  modport master (
    output start, op, a, b, drIn,
    input  busy, done, result, drOut, ldReg, divZero, err
  );

  modport slave (
    input  start, op, a, b, drIn,
    output busy, done, result, drOut, ldReg, divZero, err
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier and restoring divider, one operand bit per cycle,
// with a one-cycle writeback strobe for the LC-3 register file.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_div_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       dr_q, dr_d;
  logic             divZero_q, divZero_d;
  logic             err_q, err_d;

  logic             isDiv;
  logic [WIDTH-1:0] mulSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remSub;
  logic             remGe;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quotNext;

  // opA doubles as multiplicand (MUL) and dividend/quotient shifter (DIV);
  // acc is the product accumulator or the partial remainder.
  assign isDiv    = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign mulSum   = opB_q[0] ? (acc_q + opA_q) : acc_q;
  assign remShift = {acc_q, opA_q[WIDTH-1]};
  assign remGe    = (remShift >= {1'b0, opB_q});
  assign remSub   = remShift - {1'b0, opB_q};
  assign remNext  = remGe ? remSub[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign quotNext = {opA_q[WIDTH-2:0], remGe};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    acc_d     = acc_q;
    result_d  = result_q;
    dr_d      = dr_q;
    divZero_d = divZero_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d      = bus.op;
          opA_d     = bus.a;
          opB_d     = bus.b;
          dr_d      = bus.drIn;
          acc_d     = '0;
          count_d   = '0;
          divZero_d = 1'b0;
          err_d     = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (op_q == OP_ILL) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else if (isDiv && (opB_q == '0)) begin
          result_d  = (op_q == OP_DIVU) ? '1 : opA_q;
          divZero_d = 1'b1;
          state_d   = DONE;
        end else begin
          if (op_q == OP_MUL) begin
            acc_d = mulSum;
            opA_d = opA_q << 1;
            opB_d = opB_q >> 1;
          end else begin
            acc_d = remNext;
            opA_d = quotNext;
          end
          count_d = count_q + CW'(1);
          // The last iteration's value goes straight into Result so DONE can present it.
          if (count_q == CW'(WIDTH - 1)) begin
            if (op_q == OP_MUL) begin
              result_d = mulSum;
            end else if (op_q == OP_DIVU) begin
              result_d = quotNext;
            end else begin
              result_d = remNext;
            end
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      dr_q      <= '0;
      divZero_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      dr_q      <= dr_d;
      divZero_q <= divZero_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.ldReg   = (state_q == DONE);
  assign bus.result  = result_q;
  assign bus.drOut   = dr_q;
  assign bus.divZero = divZero_q;
  assign bus.err     = err_q;
endmodule
